mac_seq_ctrl: RTL

//   Sequencer for the 16-bit low-power MAC. Runs a dot product of LEN operand pairs on one

---
 rtl/mac_pkg.sv | 20 ++
 rtl/gp_prefix_adder.sv | 33 +++
 rtl/mac_seq_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the low-power MAC sequencer: state encoding, width defaults
// and the accumulator width legality check.
package mac_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ACC_W_DEF  = 40;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_MUL   = 3'd2,
      ST_ACC   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // A full product must fit the accumulator so only accumulation can overflow.
   function automatic bit acc_w_ok(int data_w, int acc_w);
      return acc_w >= 2 * data_w;
   endfunction
endpackage

// File: rtl/gp_prefix_adder.sv
// W-bit generate/propagate parallel-prefix (Kogge-Stone) adder, carry-in 0, with carry-out.
module gp_prefix_adder #(
   parameter int W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         cout
);
   localparam int LVL = (W > 1) ? $clog2(W) : 1;

   logic [W-1:0] g_cur, p_cur, g_nxt, p_nxt;

   always_comb begin
      g_cur = a & b;
      p_cur = a ^ b;
      g_nxt = g_cur;
      p_nxt = p_cur;
      for (int l = 0; l < LVL; l++) begin
         g_nxt = g_cur;
         p_nxt = p_cur;
         for (int i = (1 << l); i < W; i++) begin
            g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
            p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
         end
         g_cur = g_nxt;
         p_cur = p_nxt;
      end
      // Group generate of bits [i:0] is the carry into bit i+1.
      sum  = (a ^ b) ^ {g_cur[W-2:0], 1'b0};
      cout = g_cur[W-1];
   end
endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: shift-add multiply and accumulate time-share one prefix adder,
// with valid/ready streams on the operand and result sides.
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_ovf,
   output logic              busy
);
   if (!acc_w_ok(DATA_W, ACC_W)) begin : g_acc_w_chk
      $error("mac_seq_ctrl: ACC_W must be >= 2*DATA_W");
   end

   localparam int STEP_W = $clog2(DATA_W + 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [STEP_W-1:0]   step;
   logic [ACC_W-1:0]    acc, prod, mcand;
   logic [DATA_W-1:0]   mplier;
   logic                ovf;
   logic [ACC_W-1:0]    add_a, add_b, add_sum;
   logic                add_cout;

   gp_prefix_adder #(.W(ACC_W)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH: if (in_valid) state_nxt = ST_MUL;
         ST_MUL:   if (step == STEP_W'(DATA_W - 1)) state_nxt = ST_ACC;
         ST_ACC:   state_nxt = (cnt == CNT_W'(1)) ? ST_DONE : ST_FETCH;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Adder operands are selected by state alone and held at zero when idle to avoid toggling.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      add_a     = '0;
      add_b     = '0;
      case (state)
         ST_IDLE:  busy = 1'b0;
         ST_FETCH: in_ready = 1'b1;
         ST_MUL:   begin add_a = prod; add_b = mcand; end
         ST_ACC:   begin add_a = acc;  add_b = prod;  end
         ST_DONE:  out_valid = 1'b1;
         default:  busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         step   <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               acc <= '0;
               ovf <= 1'b0;
               cnt <= len;
            end
            ST_FETCH: if (in_valid) begin
               mcand  <= ACC_W'(in_a);
               mplier <= in_b;
               prod   <= '0;
               step   <= '0;
            end
            ST_MUL: begin
               if (mplier[0]) prod <= add_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               step   <= step + STEP_W'(1);
            end
            ST_ACC: begin
               acc <= add_sum;
               ovf <= ovf | add_cout;
               cnt <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign out_acc = acc;
   assign out_ovf = ovf;
endmodule
